operand_dispenser: RTL and testbench

//   Inverse of the operand accumulator. Captures a bundle of up to three

---
 rtl/operand_dispenser_if.sv | 32 +++
 rtl/operand_dispenser.sv | 112 +++++++++++
 tb/tb_operand_dispenser.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/operand_dispenser_if.sv
// Handshake bundle between a producer that loads operand bundles and
// the dispenser that hands them out one per get.
interface operand_dispenser_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             in0_valid;
    logic             in1_valid;
    logic             in2_valid;
    logic             get;
    logic [WIDTH-1:0] value;
    logic             value_valid;
    logic [1:0]       remaining;
    logic             busy;
    logic             done;
    logic             err;

    // Producer / consumer side: drives load, slots and get.
    modport master (
        output load, in0, in1, in2, in0_valid, in1_valid, in2_valid, get,
        input  value, value_valid, remaining, busy, done, err
    );

    // Dispenser side.
    modport slave (
        input  load, in0, in1, in2, in0_valid, in1_valid, in2_valid, get,
        output value, value_valid, remaining, busy, done, err
    );
endinterface

// File: rtl/operand_dispenser.sv
// Operand dispenser: captures up to three operands in one load and hands
// them out one per get, lowest valid slot first. Empty slots are skipped.
module operand_dispenser #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    operand_dispenser_if.slave     bus
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] slot_q [3];
    logic [2:0]       vld_q;
    logic [WIDTH-1:0] value_q;
    logic             value_valid_q;
    logic [1:0]       remaining_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] pop_data;
    logic [2:0]       pop_clr;
    logic [1:0]       load_cnt;

    // Lowest-index held slot and the flag mask that removes it.
    always_comb begin
        pop_data = '0;
        pop_clr  = 3'b000;
        if (vld_q[0]) begin
            pop_data = slot_q[0];
            pop_clr  = 3'b001;
        end else if (vld_q[1]) begin
            pop_data = slot_q[1];
            pop_clr  = 3'b010;
        end else if (vld_q[2]) begin
            pop_data = slot_q[2];
            pop_clr  = 3'b100;
        end
    end

    // Number of operands in the bundle being offered on the load port.
    always_comb begin
        load_cnt = {1'b0, bus.in0_valid} + {1'b0, bus.in1_valid} + {1'b0, bus.in2_valid};
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q[0]     <= '0;
            slot_q[1]     <= '0;
            slot_q[2]     <= '0;
            vld_q         <= 3'b000;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            remaining_q   <= 2'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // Pulses default low; value holds its last dispensed operand.
            value_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A get here has nothing to pop, even alongside a load.
                    err_q <= bus.get;
                    if (bus.load) begin
                        slot_q[0]   <= bus.in0;
                        slot_q[1]   <= bus.in1;
                        slot_q[2]   <= bus.in2;
                        vld_q       <= {bus.in2_valid, bus.in1_valid, bus.in0_valid};
                        remaining_q <= load_cnt;
                        if (load_cnt != 2'd0) begin
                            state_q <= SERVE;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    // Loads are refused while a bundle is still held.
                    err_q <= bus.load;
                    if (bus.get && remaining_q != 2'd0) begin
                        value_q       <= pop_data;
                        value_valid_q <= 1'b1;
                        vld_q         <= vld_q & ~pop_clr;
                        remaining_q   <= remaining_q - 2'd1;
                        if (remaining_q == 2'd1) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.remaining   = remaining_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_operand_dispenser.sv
// Directed bench for operand_dispenser: linear stimulus, hand-computed
// expectations checked with immediate assertions.
module tb_operand_dispenser;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    operand_dispenser_if #(.WIDTH(8)) bus ();

    operand_dispenser #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic l, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [2:0] v);
        bus.load      = l;
        bus.in0       = a;
        bus.in1       = b;
        bus.in2       = c;
        bus.in0_valid = v[0];
        bus.in1_valid = v[1];
        bus.in2_valid = v[2];
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        rst_n  = 1'b1;
        bus.get = 1'b0;
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 3'b000);

        // 1. Reset asserted mid-cycle, checked before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_value", bus.value, 0);
        chk("rst_vv", bus.value_valid, 0);
        chk("rst_rem", bus.remaining, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // 2. Full bundle, three back-to-back gets.
        set_load(1'b1, 8'h11, 8'h22, 8'h33, 3'b111);
        tick();
        chk("t2_load_rem", bus.remaining, 3);
        chk("t2_load_busy", bus.busy, 1);
        chk("t2_load_vv", bus.value_valid, 0);
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        bus.get = 1'b1;
        tick();
        chk("t2_v0", bus.value, 8'h11);
        chk("t2_vv0", bus.value_valid, 1);
        chk("t2_rem0", bus.remaining, 2);
        chk("t2_done0", bus.done, 0);
        tick();
        chk("t2_v1", bus.value, 8'h22);
        chk("t2_rem1", bus.remaining, 1);
        chk("t2_done1", bus.done, 0);
        tick();
        chk("t2_v2", bus.value, 8'h33);
        chk("t2_vv2", bus.value_valid, 1);
        chk("t2_rem2", bus.remaining, 0);
        chk("t2_done2", bus.done, 1);
        chk("t2_busy2", bus.busy, 0);
        bus.get = 1'b0;
        tick();
        chk("t2_hold_value", bus.value, 8'h33);
        chk("t2_hold_vv", bus.value_valid, 0);
        chk("t2_done_pulse", bus.done, 0);

        // 3. Sparse bundle, middle slot skipped.
        set_load(1'b1, 8'hA5, 8'h00, 8'h5A, 3'b101);
        tick();
        chk("t3_rem", bus.remaining, 2);
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        bus.get = 1'b1;
        tick();
        chk("t3_v0", bus.value, 8'hA5);
        chk("t3_done0", bus.done, 0);
        tick();
        chk("t3_v1", bus.value, 8'h5A);
        chk("t3_done1", bus.done, 1);
        chk("t3_rem1", bus.remaining, 0);

        // 4. get in IDLE, then an empty bundle.
        tick();
        chk("t4_err", bus.err, 1);
        chk("t4_err_vv", bus.value_valid, 0);
        bus.get = 1'b0;
        set_load(1'b1, 8'h12, 8'h34, 8'h56, 3'b000);
        tick();
        chk("t4_err_pulse", bus.err, 0);
        chk("t4_done", bus.done, 1);
        chk("t4_busy", bus.busy, 0);
        chk("t4_vv", bus.value_valid, 0);
        chk("t4_rem", bus.remaining, 0);
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        tick();
        chk("t4_done_pulse", bus.done, 0);

        // 5. Load during SERVE is refused; concurrent get still pops.
        set_load(1'b1, 8'h01, 8'h02, 8'h03, 3'b111);
        tick();
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        bus.get = 1'b1;
        tick();
        chk("t5_v0", bus.value, 8'h01);
        chk("t5_rem0", bus.remaining, 2);
        set_load(1'b1, 8'h77, 8'h88, 8'h99, 3'b111);
        tick();
        chk("t5_err", bus.err, 1);
        chk("t5_v1", bus.value, 8'h02);
        chk("t5_rem1", bus.remaining, 1);
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        tick();
        chk("t5_err_pulse", bus.err, 0);
        chk("t5_v2", bus.value, 8'h03);
        chk("t5_done", bus.done, 1);
        bus.get = 1'b0;
        tick();

        // 6. Reset after the first pop discards the rest of the bundle.
        set_load(1'b1, 8'h44, 8'h55, 8'h66, 3'b111);
        tick();
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        bus.get = 1'b1;
        tick();
        chk("t6_v0", bus.value, 8'h44);
        bus.get = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_rem", bus.remaining, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_value", bus.value, 0);
        tick();
        rst_n = 1'b1;
        bus.get = 1'b1;
        tick();
        chk("t6_err", bus.err, 1);
        chk("t6_vv", bus.value_valid, 0);
        chk("t6_busy", bus.busy, 0);
        bus.get = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
